// File: rtl/bus_arbiter_if.sv
// Master-side bus bundle for the two-master arbiter: requests, addresses,
// write controls, grants, read data and the shared address/write-enable.
interface bus_arbiter_if;
  logic       REQ0, REQ1;
  logic [7:0] ADDR0, ADDR1;
  logic       WE0, WE1;
  logic [7:0] WDATA0, WDATA1;
  logic       GNT0, GNT1;
  logic [7:0] RDATA;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (
    output REQ0, REQ1, ADDR0, ADDR1, WE0, WE1, WDATA0, WDATA1,
    input  GNT0, GNT1, RDATA, BUS_ADDR, BUS_WE
  );

  modport slave (
    input  REQ0, REQ1, ADDR0, ADDR1, WE0, WE1, WDATA0, WDATA1,
    output GNT0, GNT1, RDATA, BUS_ADDR, BUS_WE
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (CPU = master 0, DMA = master 1).
// Round-robin on contention with a bounded hold time, one idle HANDOVER
// cycle between owners, muxed address/write path and registered read data.
// The tristate data net stays a direct port so the resolved wire lives at
// the module boundary rather than inside the interface bundle.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD  = 16,
  parameter logic [7:0]  IDLE_ADDR = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  bus_arbiter_if.slave bus,
  inout  wire  [7:0] BUS_DATA
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HANDOVER} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] rdata_q, rdata_d;
  logic       gnt0_q, gnt1_q;

  logic       sel0, sel1;
  logic       bus_we;
  logic [7:0] wdata_mux;

  // Output path follows the current state, so an asynchronous reset of the
  // state releases the bus at once without waiting for a clock edge.
  assign sel0      = (state_q == GRANT0);
  assign sel1      = (state_q == GRANT1);
  assign bus_we    = (sel0 & bus.WE0 & bus.REQ0) | (sel1 & bus.WE1 & bus.REQ1);
  assign wdata_mux = sel1 ? bus.WDATA1 : bus.WDATA0;

  assign bus.BUS_ADDR = sel0 ? bus.ADDR0 : (sel1 ? bus.ADDR1 : IDLE_ADDR);
  assign bus.BUS_WE   = bus_we;
  assign bus.GNT0     = gnt0_q;
  assign bus.GNT1     = gnt1_q;
  assign bus.RDATA    = rdata_q;
  assign BUS_DATA     = bus_we ? wdata_mux : 'z;

  // Next-state, fairness pointer, hold counter and read-data capture.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, HANDOVER: begin
        // On contention the master that did not own the bus last wins.
        if (bus.REQ0 && (!bus.REQ1 || last_q)) begin
          state_d = GRANT0;
          last_d  = 1'b0;
          hold_d  = '0;
        end else if (bus.REQ1) begin
          state_d = GRANT1;
          last_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (!bus.REQ0 || (bus.REQ1 && hold_q == HOLD_MAX)) state_d = HANDOVER;
        else if (hold_q != HOLD_MAX)                       hold_d  = hold_q + 8'd1;
      end
      GRANT1: begin
        if (!bus.REQ1 || (bus.REQ0 && hold_q == HOLD_MAX)) state_d = HANDOVER;
        else if (hold_q != HOLD_MAX)                       hold_d  = hold_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // HANDOVER still samples the bus: it catches the reply to a read
    // issued in the final granted cycle.
    rdata_d = rdata_q;
    if (state_q != IDLE && !bus_we) rdata_d = BUS_DATA;
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      rdata_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      gnt0_q  <= (state_d == GRANT0);
      gnt1_q  <= (state_d == GRANT1);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (MAX_HOLD = 4): vector table for the
// basic grant/mux behaviour, hand sequences for rotation, read capture
// across HANDOVER and asynchronous reset.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  wire  [7:0] bus_data;
  logic       tb_oe;
  logic [7:0] tb_val;

  int n_chk  = 0;
  int n_fail = 0;

  bus_arbiter_if bif();

  bus_arbiter #(.MAX_HOLD(4), .IDLE_ADDR(8'hFF)) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .bus      (bif),
    .BUS_DATA (bus_data)
  );

  // Bench-side driver: peripheral read data, or a marker value used to
  // prove the arbiter is not driving the shared data net.
  assign bus_data = tb_oe ? tb_val : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
    bif.REQ0 = r0;   bif.REQ1 = r1;
    bif.WE0  = w0;   bif.WE1  = w1;
    bif.ADDR0 = a0;  bif.ADDR1 = a1;
    bif.WDATA0 = d0; bif.WDATA1 = d1;
  endtask

  typedef struct {
    logic       r0, r1, w0, w1;
    logic [7:0] a0, a1, d0, d1;
    logic       eg0, eg1;
    logic [7:0] eaddr;
    logic       ewe;
    logic [7:0] edata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // r0 r1 w0 w1  a0     a1     d0     d1    | g0 g1 addr  we data
    vecs[0]  = '{1,0,1,0, 8'hD0, 8'h00, 8'h5A, 8'h00, 1,0, 8'hD0, 1, 8'h5A}; // lone CPU write
    vecs[1]  = '{1,0,0,0, 8'hD2, 8'h00, 8'h5A, 8'h00, 1,0, 8'hD2, 0, 8'hC3}; // CPU read, addr follows
    vecs[2]  = '{0,0,1,0, 8'hD2, 8'h00, 8'h5A, 8'h00, 0,0, 8'hFF, 0, 8'hC3}; // REQ0 drops -> HANDOVER
    vecs[3]  = '{0,0,0,1, 8'h00, 8'hD1, 8'h00, 8'hA5, 0,0, 8'hFF, 0, 8'hC3}; // IDLE, WE1 ignored
    vecs[4]  = '{0,1,0,1, 8'h00, 8'hD1, 8'h00, 8'hA5, 0,1, 8'hD1, 1, 8'hA5}; // lone DMA write
    vecs[5]  = '{0,1,0,1, 8'h00, 8'hD1, 8'h00, 8'hA5, 0,1, 8'hD1, 1, 8'hA5};
    vecs[6]  = '{0,1,0,1, 8'h00, 8'hD1, 8'h00, 8'hA5, 0,1, 8'hD1, 1, 8'hA5};
    vecs[7]  = '{0,1,0,1, 8'h00, 8'hD1, 8'h00, 8'hA5, 0,1, 8'hD1, 1, 8'hA5}; // hold saturates
    vecs[8]  = '{0,1,0,1, 8'h00, 8'hD1, 8'h00, 8'hA5, 0,1, 8'hD1, 1, 8'hA5}; // still no handover
    vecs[9]  = '{1,1,0,0, 8'hD0, 8'hD1, 8'h00, 8'hA5, 0,0, 8'hFF, 0, 8'hC3}; // saturated + rival
    vecs[10] = '{1,1,0,0, 8'hD0, 8'hD1, 8'h00, 8'hA5, 1,0, 8'hD0, 0, 8'hC3}; // last=1 -> CPU

    // Reset held low with both masters requesting and writing.
    rst_n = 1'b0;
    tb_oe = 1'b1; tb_val = 8'hC3;
    set_in(1, 1, 1, 1, 8'hD0, 8'hD1, 8'h5A, 8'hA5);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt0", {7'd0, bif.GNT0}, 8'd0);
    chk("rst_gnt1", {7'd0, bif.GNT1}, 8'd0);
    chk("rst_addr", bif.BUS_ADDR, 8'hFF);
    chk("rst_we",   {7'd0, bif.BUS_WE}, 8'd0);
    chk("rst_data_z", bus_data, 8'hC3);
    chk("rst_rdata", bif.RDATA, 8'h00);

    @(negedge clk);
    set_in(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_in(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
             vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      tb_oe  = !vecs[i].ewe;
      tb_val = 8'hC3;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_gnt0", i), {7'd0, bif.GNT0}, {7'd0, vecs[i].eg0});
      chk($sformatf("v%0d_gnt1", i), {7'd0, bif.GNT1}, {7'd0, vecs[i].eg1});
      chk($sformatf("v%0d_addr", i), bif.BUS_ADDR, vecs[i].eaddr);
      chk($sformatf("v%0d_we", i),   {7'd0, bif.BUS_WE}, {7'd0, vecs[i].ewe});
      chk($sformatf("v%0d_data", i), bus_data, vecs[i].edata);
    end

    // Back to IDLE, then sustained contention: CPU owned last, so DMA first.
    @(negedge clk);
    set_in(0, 0, 0, 0, 8'hD0, 8'hD1, 8'h00, 8'h00);
    tb_oe = 1'b1; tb_val = 8'hC3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_in(1, 1, 0, 0, 8'hD0, 8'hD1, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      int pos;
      logic eg0, eg1;
      pos = i % 10;
      eg1 = (pos <= 3);
      eg0 = (pos >= 5 && pos <= 8);
      @(posedge clk);
      #1;
      chk($sformatf("rot%0d_gnt0", i), {7'd0, bif.GNT0}, {7'd0, eg0});
      chk($sformatf("rot%0d_gnt1", i), {7'd0, bif.GNT1}, {7'd0, eg1});
      chk($sformatf("rot%0d_excl", i), {7'd0, bif.GNT0 & bif.GNT1}, 8'd0);
      chk($sformatf("rot%0d_addr", i), bif.BUS_ADDR, eg0 ? 8'hD0 : (eg1 ? 8'hD1 : 8'hFF));
    end

    // DMA read in its last granted cycle; reply lands during HANDOVER.
    @(negedge clk);
    set_in(0, 0, 0, 0, 8'hD0, 8'hD1, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1, 0, 0, 8'h00, 8'hD1, 8'h00, 8'h00);
    tb_oe = 1'b1; tb_val = 8'h11;
    @(posedge clk);
    #1;
    chk("rd_gnt1", {7'd0, bif.GNT1}, 8'd1);
    chk("rd_addr", bif.BUS_ADDR, 8'hD1);
    @(negedge clk);
    bif.REQ1 = 1'b0;
    @(posedge clk);
    #1;
    chk("rd_ho_gnt1", {7'd0, bif.GNT1}, 8'd0);
    chk("rd_ho_addr", bif.BUS_ADDR, 8'hFF);
    chk("rd_stale", bif.RDATA, 8'h11);
    tb_val = 8'h3C;
    @(posedge clk);
    #1;
    chk("rd_capture", bif.RDATA, 8'h3C);
    tb_val = 8'h77;
    @(posedge clk);
    #1;
    chk("rd_hold_idle", bif.RDATA, 8'h3C);

    // Asynchronous reset in the middle of a DMA write.
    @(negedge clk);
    tb_oe = 1'b0;
    set_in(0, 1, 0, 1, 8'h00, 8'hD1, 8'h00, 8'h96);
    @(posedge clk);
    #1;
    chk("ar_gnt1", {7'd0, bif.GNT1}, 8'd1);
    chk("ar_we", {7'd0, bif.BUS_WE}, 8'd1);
    chk("ar_data", bus_data, 8'h96);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rst_gnt1", {7'd0, bif.GNT1}, 8'd0);
    chk("ar_rst_we", {7'd0, bif.BUS_WE}, 8'd0);
    chk("ar_rst_addr", bif.BUS_ADDR, 8'hFF);
    chk("ar_rst_rdata", bif.RDATA, 8'h00);
    tb_oe = 1'b1; tb_val = 8'hC3;
    #1;
    chk("ar_rst_data_z", bus_data, 8'hC3);
    @(negedge clk);
    tb_oe = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_gnt1", {7'd0, bif.GNT1}, 8'd0);
    @(posedge clk);
    #1;
    chk("ar_regrant", {7'd0, bif.GNT1}, 8'd1);
    chk("ar_regrant_data", bus_data, 8'h96);

    // Simultaneous request after reset: CPU first, then HANDOVER, then DMA.
    @(negedge clk);
    rst_n = 1'b0;
    tb_oe = 1'b1; tb_val = 8'hC3;
    set_in(1, 1, 0, 0, 8'hD0, 8'hD1, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("sim_gnt0", {7'd0, bif.GNT0}, 8'd1);
    chk("sim_gnt1", {7'd0, bif.GNT1}, 8'd0);
    @(negedge clk);
    bif.REQ0 = 1'b0;
    @(posedge clk);
    #1;
    chk("sim_ho_gnt", {6'd0, bif.GNT0, bif.GNT1}, 8'd0);
    chk("sim_ho_addr", bif.BUS_ADDR, 8'hFF);
    @(posedge clk);
    #1;
    chk("sim_gnt1_after", {6'd0, bif.GNT0, bif.GNT1}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
